// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types, defaults and timer sizing for the parking gate arbiter
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PASS,
        OPEN,
        CLOSE
    } gate_state_t;

    typedef enum logic {
        ENTRY,
        EXIT
    } lane_t;

    localparam int DEF_CAPACITY     = 8;
    localparam int DEF_CNT_W        = 4;
    localparam int DEF_PASS_TIMEOUT = 100;
    localparam int DEF_GATE_TIMEOUT = 50;

    function automatic int timer_w(input int pass_timeout, input int gate_timeout);
        int longest;
        longest = (pass_timeout > gate_timeout) ? pass_timeout : gate_timeout;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - loadable down-counter shared by the credential and gate-open timeouts
module gate_timer
    import parking_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    // Flags the last cycle of the window: the count reaches 0 on the coming edge,
    // so a window loaded with N lasts exactly N cycles.
    assign expired = (count == W'(1));

endmodule

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - shares the barrier gate between entry and exit lanes, owns occupancy
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int PASS_TIMEOUT = DEF_PASS_TIMEOUT,
    parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             pass_ok,
    input  logic             pass_fail,
    input  logic             car_passed,
    output logic             gate_open,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             deny
);

    localparam int               TW       = timer_w(PASS_TIMEOUT, GATE_TIMEOUT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CAPACITY);

    gate_state_t      state, state_n;
    lane_t            rr_last, rr_last_n;
    logic [CNT_W-1:0] occ_n;
    logic             gate_open_n, grant_entry_n, grant_exit_n, deny_n;
    logic             entry_req_d;
    logic             entry_ok, exit_ok;
    logic             timer_load, timer_expired;
    logic [TW-1:0]    timer_value;

    gate_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    always_comb begin
        state_n       = state;
        rr_last_n     = rr_last;
        occ_n         = occupancy;
        gate_open_n   = gate_open;
        grant_entry_n = grant_entry;
        grant_exit_n  = grant_exit;
        deny_n        = 1'b0;
        timer_load    = 1'b0;
        timer_value   = '0;
        entry_ok      = entry_req && !lot_full;
        exit_ok       = exit_req && !lot_empty;

        case (state)
            IDLE: begin
                gate_open_n   = 1'b0;
                grant_entry_n = 1'b0;
                grant_exit_n  = 1'b0;
                // On contention the lane that did not win last time goes first.
                if (entry_ok && (!exit_ok || rr_last == EXIT)) begin
                    state_n       = WAIT_PASS;
                    grant_entry_n = 1'b1;
                    rr_last_n     = ENTRY;
                    timer_load    = 1'b1;
                    timer_value   = TW'(PASS_TIMEOUT);
                end else if (exit_ok) begin
                    state_n      = OPEN;
                    grant_exit_n = 1'b1;
                    gate_open_n  = 1'b1;
                    rr_last_n    = EXIT;
                    timer_load   = 1'b1;
                    timer_value  = TW'(GATE_TIMEOUT);
                end else if (entry_req && !entry_req_d && lot_full) begin
                    deny_n = 1'b1;
                end
            end
            WAIT_PASS: begin
                if (pass_fail) begin
                    state_n       = IDLE;
                    grant_entry_n = 1'b0;
                    deny_n        = 1'b1;
                end else if (!entry_req) begin
                    state_n       = IDLE;
                    grant_entry_n = 1'b0;
                end else if (pass_ok) begin
                    state_n     = OPEN;
                    gate_open_n = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = TW'(GATE_TIMEOUT);
                end else if (timer_expired) begin
                    state_n       = IDLE;
                    grant_entry_n = 1'b0;
                    deny_n        = 1'b1;
                end
            end
            OPEN: begin
                if (car_passed) begin
                    occ_n       = grant_entry ? occupancy + CNT_W'(1) : occupancy - CNT_W'(1);
                    state_n     = CLOSE;
                    gate_open_n = 1'b0;
                end else if (timer_expired) begin
                    state_n     = CLOSE;
                    gate_open_n = 1'b0;
                end
            end
            CLOSE: begin
                state_n       = IDLE;
                gate_open_n   = 1'b0;
                grant_entry_n = 1'b0;
                grant_exit_n  = 1'b0;
            end
            default: begin
                state_n       = IDLE;
                gate_open_n   = 1'b0;
                grant_entry_n = 1'b0;
                grant_exit_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_last     <= EXIT;
            occupancy   <= '0;
            lot_full    <= 1'b0;
            lot_empty   <= 1'b1;
            gate_open   <= 1'b0;
            grant_entry <= 1'b0;
            grant_exit  <= 1'b0;
            deny        <= 1'b0;
            entry_req_d <= 1'b0;
        end else begin
            state       <= state_n;
            rr_last     <= rr_last_n;
            occupancy   <= occ_n;
            lot_full    <= (occ_n == FULL_CNT);
            lot_empty   <= (occ_n == '0);
            gate_open   <= gate_open_n;
            grant_entry <= grant_entry_n;
            grant_exit  <= grant_exit_n;
            deny        <= deny_n;
            entry_req_d <= entry_req;
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - scoreboard bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

    localparam int CAP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       pass_ok = 1'b0;
    logic       pass_fail = 1'b0;
    logic       car_passed = 1'b0;
    logic       gate_open, grant_entry, grant_exit, lot_full, lot_empty, deny;
    logic [3:0] occupancy;

    parking_gate_arbiter #(
        .CAPACITY(CAP), .CNT_W(4), .PASS_TIMEOUT(100), .GATE_TIMEOUT(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
        .pass_ok(pass_ok), .pass_fail(pass_fail), .car_passed(car_passed),
        .gate_open(gate_open), .grant_entry(grant_entry), .grant_exit(grant_exit),
        .occupancy(occupancy), .lot_full(lot_full), .lot_empty(lot_empty), .deny(deny)
    );

    always #5 clk = ~clk;

    // Expected output snapshot {gate_open, grant_entry, grant_exit, deny, lot_full, lot_empty, occupancy}
    // and the cycles since the previous output change (0 = not checked).
    typedef struct {
        logic [9:0] snap;
        int         delta;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_evt = 0;
    logic [9:0] prev = 'x;

    function automatic logic [9:0] mk(input bit go, input bit ge, input bit gx, input bit dn, input int occ);
        logic [3:0] o;
        o = occ[3:0];
        return {go, ge, gx, dn, occ == CAP, occ == 0, o};
    endfunction

    task automatic push(input bit go, input bit ge, input bit gx, input bit dn, input int occ, input int delta);
        exp_t e;
        e.snap  = mk(go, ge, gx, dn, occ);
        e.delta = delta;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [9:0] snap;
        exp_t       e;
        cyc++;
        snap = {gate_open, grant_entry, grant_exit, deny, lot_full, lot_empty, occupancy};
        if (rst_n) begin
            checks++;
            if (occupancy > 4'(CAP) || (grant_entry && grant_exit) ||
                (gate_open && !(grant_entry ^ grant_exit))) begin
                errors++;
                $display("FAIL invariant cyc=%0d got occ=%0d ge=%b gx=%b go=%b, required occ<=%0d, one grant, gate only with one grant",
                         cyc, occupancy, grant_entry, grant_exit, gate_open, CAP);
            end
        end
        if (snap !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got=%h, required no change", cyc, snap);
            end else begin
                e = exp_q.pop_front();
                if (snap !== e.snap || (e.delta != 0 && cyc - last_evt != e.delta)) begin
                    errors++;
                    $display("FAIL event cyc=%0d got=%h after %0d cycles, required=%h after %0d cycles",
                             cyc, snap, cyc - last_evt, e.snap, e.delta);
                end
            end
            last_evt = cyc;
            prev     = snap;
        end
    end

    task automatic do_entry(input int occ);
        push(0, 1, 0, 0, occ, 0);
        push(1, 1, 0, 0, occ, 3);
        push(0, 1, 0, 0, occ + 1, 5);
        push(0, 0, 0, 0, occ + 1, 1);
        entry_req = 1'b1; step(3);
        pass_ok = 1'b1; step(1); pass_ok = 1'b0; step(4);
        car_passed = 1'b1; step(1); car_passed = 1'b0; entry_req = 1'b0; step(3);
    endtask

    task automatic do_exit(input int occ);
        push(1, 0, 1, 0, occ, 0);
        push(0, 0, 1, 0, occ - 1, 2);
        push(0, 0, 0, 0, occ - 1, 1);
        exit_req = 1'b1; step(2);
        car_passed = 1'b1; step(1); car_passed = 1'b0; exit_req = 1'b0; step(3);
    endtask

    initial begin
        push(0, 0, 0, 0, 0, 0);
        step(3); rst_n = 1'b1; step(2);

        for (int k = 0; k < 4; k++) do_entry(k);
        do_exit(4);

        // Both lanes held at occupancy 3: entry, exit, entry.
        push(0, 1, 0, 0, 3, 0); push(1, 1, 0, 0, 3, 1); push(0, 1, 0, 0, 4, 1); push(0, 0, 0, 0, 4, 1);
        push(1, 0, 1, 0, 4, 1); push(0, 0, 1, 0, 3, 1); push(0, 0, 0, 0, 3, 1);
        push(0, 1, 0, 0, 3, 1); push(1, 1, 0, 0, 3, 1); push(0, 1, 0, 0, 4, 1); push(0, 0, 0, 0, 4, 1);
        entry_req = 1'b1; exit_req = 1'b1; step(1);
        pass_ok = 1'b1; step(1); pass_ok = 1'b0;
        car_passed = 1'b1; step(1); car_passed = 1'b0;
        step(2); car_passed = 1'b1; step(1); car_passed = 1'b0;
        step(1); exit_req = 1'b0;
        step(1);
        pass_ok = 1'b1; step(1); pass_ok = 1'b0;
        car_passed = 1'b1; step(1); car_passed = 1'b0; entry_req = 1'b0; step(3);

        for (int k = 4; k < 8; k++) do_entry(k);

        // Full lot: deny pulse, exit frees a space, held entry gets granted then aborts.
        push(0, 0, 0, 1, 8, 0); push(0, 0, 0, 0, 8, 1);
        entry_req = 1'b1; step(3);
        push(1, 0, 1, 0, 8, 0); push(0, 0, 1, 0, 7, 1); push(0, 0, 0, 0, 7, 1);
        push(0, 1, 0, 0, 7, 1); push(0, 0, 0, 0, 7, 1);
        exit_req = 1'b1; step(1);
        car_passed = 1'b1; step(1); car_passed = 1'b0; exit_req = 1'b0;
        step(2); entry_req = 1'b0; step(3);

        // Credential timeout.
        push(0, 1, 0, 0, 7, 0); push(0, 0, 0, 1, 7, 100); push(0, 0, 0, 0, 7, 1);
        entry_req = 1'b1; step(101); entry_req = 1'b0; step(3);

        // pass_fail alone, then pass_ok together with pass_fail.
        for (int k = 0; k < 2; k++) begin
            push(0, 1, 0, 0, 7, 0); push(0, 0, 0, 1, 7, 1); push(0, 0, 0, 0, 7, 1);
            entry_req = 1'b1; step(1);
            pass_fail = 1'b1; pass_ok = (k == 1); step(1);
            pass_fail = 1'b0; pass_ok = 1'b0; entry_req = 1'b0; step(3);
        end

        // Exit with no car: gate times out, count unchanged.
        push(1, 0, 1, 0, 7, 0); push(0, 0, 1, 0, 7, 50); push(0, 0, 0, 0, 7, 1);
        exit_req = 1'b1; step(2); exit_req = 1'b0; step(55);

        // Asynchronous reset while the gate is open.
        push(1, 0, 1, 0, 7, 0); push(0, 0, 0, 0, 0, 0);
        exit_req = 1'b1; step(1);
        @(negedge clk); #2;
        rst_n = 1'b0; exit_req = 1'b0; #1;
        checks++;
        if (gate_open !== 1'b0 || occupancy !== 4'd0 || grant_exit !== 1'b0 || lot_empty !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got go=%b occ=%0d gx=%b empty=%b, required go=0 occ=0 gx=0 empty=1",
                     gate_open, occupancy, grant_exit, lot_empty);
        end
        step(2); rst_n = 1'b1; step(2);

        // Exit request on an empty lot: no grant, no deny.
        exit_req = 1'b1; step(5); exit_req = 1'b0; step(2);
        do_entry(0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d expected events never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
